// File: rtl/popcount_pkg.sv
// Shared types and defaults for the popcount unary transmitter.
package popcount_pkg;

   localparam int unsigned N_DEFAULT  = 20;
   localparam int unsigned CW_DEFAULT = 5;

   typedef enum logic {IDLE, EMIT} state_e;

   typedef logic [CW_DEFAULT-1:0] cnt_t;

endpackage

// File: rtl/popcount_unary_tx.sv
// Count-to-unary transmitter: turns a count into an N-bit frame holding exactly that many ones.
// Define POPCOUNT_UNARY_SPREAD_EN for Bresenham-spread ones; otherwise ones lead the frame.
module popcount_unary_tx
   import popcount_pkg::*;
#(
   parameter int unsigned N  = N_DEFAULT,
   parameter int unsigned CW = CW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cnt_valid,
   output logic          cnt_ready,
   input  logic [CW-1:0] cnt_data,
   output logic          bit_valid,
   input  logic          bit_ready,
   output logic          bit_data,
   output logic          bit_last,
   output logic          clamp
);

   localparam logic [CW-1:0] N_C  = CW'(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_e        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] idx;
   logic          bit_raw;
   logic          accept_c;
   logic          beat_c;

   assign accept_c = (state == IDLE) && cnt_valid;
   assign beat_c   = bit_valid && bit_ready;

`ifdef POPCOUNT_UNARY_SPREAD_EN
   localparam int unsigned AW = CW + 1;

   logic [AW-1:0] acc;
   logic [AW-1:0] sum;
   logic [AW-1:0] acc_next;

   // Error accumulator: emit a one whenever the running sum crosses N.
   always_comb begin
      sum      = acc + AW'(cnt);
      bit_raw  = (sum >= AW'(N));
      acc_next = bit_raw ? (sum - AW'(N)) : sum;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (accept_c) begin
         acc <= '0;
      end else if (beat_c) begin
         acc <= acc_next;
      end
   end
`else
   always_comb begin
      bit_raw = (idx < cnt);
   end
`endif

   // Gated so the output reads 0 whenever no bit is offered.
   assign bit_data = bit_valid & bit_raw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         clamp     <= 1'b0;
         cnt_ready <= 1'b1;
         bit_valid <= 1'b0;
         bit_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cnt_valid) begin
                  cnt       <= (cnt_data > N_C) ? N_C : cnt_data;
                  clamp     <= (cnt_data > N_C);
                  idx       <= '0;
                  state     <= EMIT;
                  cnt_ready <= 1'b0;
                  bit_valid <= 1'b1;
                  bit_last  <= (LAST == '0);
               end
            end
            EMIT: begin
               if (bit_ready) begin
                  if (bit_last) begin
                     idx       <= '0;
                     state     <= IDLE;
                     cnt_ready <= 1'b1;
                     bit_valid <= 1'b0;
                     bit_last  <= 1'b0;
                  end else begin
                     idx      <= idx + CW'(1);
                     bit_last <= ((idx + CW'(1)) == LAST);
                  end
               end
            end
            default: begin
               state     <= IDLE;
               cnt_ready <= 1'b1;
               bit_valid <= 1'b0;
               bit_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_popcount_unary_tx.sv
// Scoreboard bench for popcount_unary_tx; the reference frame is built from arithmetic on the count.
module tb_popcount_unary_tx;
   import popcount_pkg::*;

   localparam int N  = 20;
   localparam int CW = 5;

   logic clk = 1'b0;
   logic rst_n;
   logic cnt_valid;
   logic cnt_ready;
   cnt_t cnt_data;
   logic bit_valid;
   logic bit_ready;
   logic bit_data;
   logic bit_last;
   logic clamp;

   typedef struct {
      logic d;
      logic l;
      logic c;
   } beat_t;

   beat_t exp_q[$];
   int    ones_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;
   int    beats_done = 0;
   int    frame_ones = 0;
   bit    ready_rand = 1'b0;

   popcount_unary_tx #(.N(N), .CW(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cnt_valid (cnt_valid),
      .cnt_ready (cnt_ready),
      .cnt_data  (cnt_data),
      .bit_valid (bit_valid),
      .bit_ready (bit_ready),
      .bit_data  (bit_data),
      .bit_last  (bit_last),
      .clamp     (clamp)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference frame: beat i holds a one when floor(i*c/N) steps up (spread) or i < c (leading).
   task automatic push_frame(input int c_in);
      int  c;
      bit  cl;
      beat_t b;
      c  = (c_in > N) ? N : c_in;
      cl = (c_in > N);
      for (int i = 0; i < N; i++) begin
`ifdef POPCOUNT_UNARY_SPREAD_EN
         b.d = (((i + 1) * c) / N) > ((i * c) / N);
`else
         b.d = (i < c);
`endif
         b.l = (i == N - 1);
         b.c = cl;
         exp_q.push_back(b);
      end
      ones_q.push_back(c);
   endtask

   task automatic send_count(input int c);
      int t;
      bit ok;
      t  = 0;
      ok = 1'b0;
      @(posedge clk); #1;
      cnt_valid = 1'b1;
      cnt_data  = CW'(c);
      while (t < 1000) begin
         @(negedge clk);
         if (cnt_ready) begin
            push_frame(c);
            ok = 1'b1;
            break;
         end
         t++;
      end
      @(posedge clk); #1;
      cnt_valid = 1'b0;
      if (!ok) check("accept_timeout", 0, 1);
   endtask

   // Consumer readiness: always ready or a 50% coin flip per cycle.
   initial begin
      bit_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         bit_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: pops one expected beat per handshake, checks stalls and the per-frame ones total.
   initial begin
      beat_t e;
      bit    stalled;
      logic  sd, sl;
      stalled = 1'b0;
      sd = 1'b0;
      sl = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stalled    = 1'b0;
            frame_ones = 0;
         end else begin
            if (stalled && bit_valid) begin
               check("stall_data", int'(bit_data), int'(sd));
               check("stall_last", int'(bit_last), int'(sl));
            end
            if (bit_valid) check("ready_low_in_emit", int'(cnt_ready), 0);
            if (bit_valid && bit_ready) begin
               beats_done++;
               if (exp_q.size() == 0) begin
                  check("unexpected_beat", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("bit_data", int'(bit_data), int'(e.d));
                  check("bit_last", int'(bit_last), int'(e.l));
                  check("clamp", int'(clamp), int'(e.c));
                  frame_ones += int'(bit_data);
                  if (e.l) begin
                     if (ones_q.size() != 0) check("frame_ones", frame_ones, ones_q.pop_front());
                     frame_ones = 0;
                  end
               end
            end
            stalled = bit_valid && !bit_ready;
            sd = bit_data;
            sl = bit_last;
         end
      end
   end

   initial begin
      int k;
      int target;
      rst_n      = 1'b0;
      cnt_valid  = 1'b0;
      cnt_data   = '0;
      @(posedge clk); #1;
      check("rst_cnt_ready", int'(cnt_ready), 1);
      check("rst_bit_valid", int'(bit_valid), 0);
      check("rst_bit_data", int'(bit_data), 0);
      check("rst_bit_last", int'(bit_last), 0);
      check("rst_clamp", int'(clamp), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Latency and frame length with the consumer always ready.
      send_count(5);
      check("first_bit_latency", int'(bit_valid), 1);
      k = 0;
      while (k < 100) begin
         @(posedge clk); #1;
         k++;
         if (cnt_ready) break;
      end
      check("ready_return_cycles", k, N);

      // Endpoints back-to-back, then clamp followed by a normal count.
      send_count(0);
      send_count(20);
      send_count(31);
      send_count(4);

      // Backpressure.
      ready_rand = 1'b1;
      send_count(9);

      // Reset in the middle of a frame.
      k = 0;
      while (!cnt_ready && k < 2000) begin
         @(posedge clk); #1;
         k++;
      end
      ready_rand = 1'b0;
      target = beats_done + 5;
      send_count(7);
      k = 0;
      while (beats_done < target && k < 200) begin
         @(negedge clk);
         k++;
      end
      check("midframe_beats_seen", beats_done >= target ? 1 : 0, 1);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("midrst_bit_valid", int'(bit_valid), 0);
      check("midrst_cnt_ready", int'(cnt_ready), 1);
      check("midrst_clamp", int'(clamp), 0);
      exp_q.delete();
      ones_q.delete();
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      send_count(3);

      // Sweep every legal count, then random counts including clamped ones, under random backpressure.
      ready_rand = 1'b1;
      for (int c = 0; c <= N; c++) send_count(c);
      for (int r = 0; r < 30; r++) send_count(int'($urandom_range(0, 31)));

      k = 0;
      while ((exp_q.size() != 0 || !cnt_ready) && k < 5000) begin
         @(posedge clk); #1;
         k++;
      end
      check("drain", exp_q.size(), 0);
      check("final_ready", int'(cnt_ready), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
